// File: rtl/apb_modport_if.sv
// apb_modport_if -- request-side bundle for the apb_modport subsystem.
// Carries the transfer request, direction, read/write addresses, write data
// and the registered read result between a requester and the subsystem.
//   transfer          : 1 = perform a transfer
//   READ_WRITE        : 1 = read, 0 = write
//   apb_read_paddr    : read address  (MSB selects slave)
//   apb_write_paddr   : write address (MSB selects slave)
//   apb_write_data    : write data
//   apb_read_data_out : data from the last completed read
// Modports: master = requester side, slave = apb_modport side.
interface apb_modport_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
);
  logic                  transfer;
  logic                  READ_WRITE;
  logic [ADDR_WIDTH-1:0] apb_read_paddr;
  logic [ADDR_WIDTH-1:0] apb_write_paddr;
  logic [DATA_WIDTH-1:0] apb_write_data;
  logic [DATA_WIDTH-1:0] apb_read_data_out;

  modport master (
    output transfer, READ_WRITE, apb_read_paddr, apb_write_paddr, apb_write_data,
    input  apb_read_data_out
  );

  modport slave (
    input  transfer, READ_WRITE, apb_read_paddr, apb_write_paddr, apb_write_data,
    output apb_read_data_out
  );
endinterface

// File: rtl/apb_modport.sv
// apb_modport -- one APB master (IDLE/SETUP/ACCESS) driving two APB slaves,
// each a 2**(ADDR_WIDTH-1) x DATA_WIDTH register memory (256 x 8 by default).
// Address MSB selects the slave, the remaining bits index its memory.
// Ports:
//   pclk    : clock, rising edge
//   presetn : asynchronous active-low reset (clears FSM, output, memories)
//   bus     : apb_modport_if.slave request bundle (see interface header)
// Build option: define APB_WAIT_STATE_EN to make each slave insert one wait
// state (PREADY low in the first ACCESS cycle); otherwise PREADY is always 1.
module apb_modport #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic          pclk,
  input  logic          presetn,
  apb_modport_if.slave  bus
);

  localparam int          OFS_W = ADDR_WIDTH - 1;
  localparam int unsigned DEPTH = 1 << OFS_W;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state;
  logic [1:0]            psel;
  logic                  penable;
  logic                  pwrite;
  logic [OFS_W-1:0]      paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [1:0]            pready;
  logic [DATA_WIDTH-1:0] prdata [2];
  logic [DATA_WIDTH-1:0] mem [2][DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_psel;
  logic                  pready_sel;
  logic [DATA_WIDTH-1:0] prdata_sel;

  // Request decode, used both from IDLE and for back-to-back from ACCESS.
  always_comb begin
    req_addr   = bus.READ_WRITE ? bus.apb_read_paddr : bus.apb_write_paddr;
    req_psel   = req_addr[ADDR_WIDTH-1] ? 2'b10 : 2'b01;
    pready_sel = psel[1] ? pready[1] : pready[0];
    prdata_sel = psel[1] ? prdata[1] : prdata[0];
  end

  // Master FSM with registered bus outputs.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= IDLE;
      psel    <= '0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.transfer) begin
            state   <= SETUP;
            psel    <= req_psel;
            pwrite  <= ~bus.READ_WRITE;
            paddr   <= req_addr[OFS_W-1:0];
            pwdata  <= bus.apb_write_data;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (pready_sel) begin
            if (!pwrite) rdata_q <= prdata_sel;
            penable <= 1'b0;
            if (bus.transfer) begin
              state  <= SETUP;
              psel   <= req_psel;
              pwrite <= ~bus.READ_WRITE;
              paddr  <= req_addr[OFS_W-1:0];
              pwdata <= bus.apb_write_data;
            end else begin
              state <= IDLE;
              psel  <= '0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          psel    <= '0;
          penable <= 1'b0;
        end
      endcase
    end
  end

`ifdef APB_WAIT_STATE_EN
  // waited[s] is set after the first ACCESS cycle of slave s, so PREADY rises
  // one cycle late and drops again as the access completes.
  logic [1:0] waited;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      waited <= '0;
    end else begin
      for (int unsigned s = 0; s < 2; s++)
        waited[s[0]] <= psel[s[0]] & penable & ~waited[s[0]];
    end
  end

  always_comb pready = waited;
`else
  always_comb pready = '1;
`endif

  // Slave memories: cleared by reset, written on ACCESS completion.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[0][i[OFS_W-1:0]] <= '0;
        mem[1][i[OFS_W-1:0]] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < 2; s++)
        if (psel[s[0]] & penable & pready[s[0]] & pwrite)
          mem[s[0]][paddr] <= pwdata;
    end
  end

  always_comb begin
    prdata[0] = mem[0][paddr];
    prdata[1] = mem[1][paddr];
  end

  assign bus.apb_read_data_out = rdata_q;

endmodule

// File: tb/tb_apb_modport.sv
// tb_apb_modport -- randomized scoreboard bench for apb_modport.
// The driver computes, from the transfer timing rules, the edge at which each
// read completes and pushes the expected value (from a flat memory model) into
// a queue; the monitor checks apb_read_data_out on every falling edge.
module tb_apb_modport;
  localparam int AW = 9;
  localparam int DW = 8;
`ifdef APB_WAIT_STATE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic pclk = 1'b0;
  logic presetn;
  always #5 pclk = ~pclk;

  apb_modport_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  apb_modport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  typedef struct {
    int        due;
    logic [7:0] val;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] mem_m [512];
  logic [7:0] exp_out = 8'h00;
  int         cyc = 0;
  int         busy_until = 0;
  int         checks = 0;
  int         errors = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: retire reads whose completion edge has passed, then compare.
  always @(negedge pclk) begin
    if (!presetn) begin
      sbq.delete();
      exp_out = 8'h00;
    end else begin
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        exp_out = sbq[0].val;
        void'(sbq.pop_front());
      end
    end
    check("read_data_out", bus.apb_read_data_out, exp_out);
  end

  task automatic clear_model();
    for (int i = 0; i < 512; i++) mem_m[i] = 8'h00;
    busy_until = 0;
  endtask

  task automatic idle(input int n);
    bus.transfer = 1'b0;
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  // Called at posedge+1. Sampling edge is the next edge when idle, otherwise
  // the completion edge of the previous transfer (back-to-back). Returns just
  // before the completion edge with transfer low.
  task automatic issue(input logic rd, input logic [8:0] a, input logic [7:0] d);
    int sample;
    int comp;
    bus.transfer   = 1'b1;
    bus.READ_WRITE = rd;
    bus.apb_write_data = d;
    if (rd) begin
      bus.apb_read_paddr  = a;
      bus.apb_write_paddr = 9'($urandom);
    end else begin
      bus.apb_write_paddr = a;
      bus.apb_read_paddr  = 9'($urandom);
    end
    sample = (cyc + 1 > busy_until) ? cyc + 1 : busy_until;
    comp   = sample + LAT;
    if (rd) sbq.push_back('{comp, mem_m[a]});
    else    mem_m[a] = d;
    busy_until = comp;
    while (cyc < sample) begin
      @(posedge pclk);
      #1;
    end
    // Everything but transfer-at-completion is ignored now: scramble it.
    bus.transfer        = 1'($urandom);
    bus.READ_WRITE      = 1'($urandom);
    bus.apb_read_paddr  = 9'($urandom);
    bus.apb_write_paddr = 9'($urandom);
    bus.apb_write_data  = 8'($urandom);
    while (cyc < comp - 1) begin
      @(posedge pclk);
      #1;
      bus.transfer = 1'($urandom);
    end
    bus.transfer = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] pool [10];
    logic [8:0] a;
    logic       rd;

    presetn             = 1'b0;
    bus.transfer        = 1'b0;
    bus.READ_WRITE      = 1'b0;
    bus.apb_read_paddr  = '0;
    bus.apb_write_paddr = '0;
    bus.apb_write_data  = '0;
    clear_model();
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;
    check("reset_out", bus.apb_read_data_out, 8'h00);

    // Basic write then read
    issue(1'b0, 9'h012, 8'hA5); idle(2);
    issue(1'b1, 9'h012, 8'h00); idle(2);

    // Slave isolation via address MSB
    issue(1'b0, 9'h034, 8'h11);
    issue(1'b0, 9'h134, 8'h22);
    issue(1'b1, 9'h034, 8'h00);
    issue(1'b1, 9'h134, 8'h00); idle(2);

    // Back-to-back writes, then back-to-back readback
    issue(1'b0, 9'h000, 8'h3C);
    issue(1'b0, 9'h001, 8'hC3);
    issue(1'b0, 9'h002, 8'h7E);
    issue(1'b1, 9'h000, 8'h00);
    issue(1'b1, 9'h001, 8'h00);
    issue(1'b1, 9'h002, 8'h00); idle(2);

    // Unwritten location, then a write must not disturb the output
    issue(1'b1, 9'h1FF, 8'h00); idle(1);
    issue(1'b0, 9'h1FF, 8'h5A); idle(4);
    issue(1'b1, 9'h1FF, 8'h00); idle(2);
    issue(1'b1, 9'h012, 8'h00); idle(2);

    // Reset asserted during SETUP of a write aborts it
    bus.transfer        = 1'b1;
    bus.READ_WRITE      = 1'b0;
    bus.apb_write_paddr = 9'h050;
    bus.apb_write_data  = 8'hFF;
    @(posedge pclk);
    #1 bus.transfer = 1'b0;
    #2 presetn = 1'b0;
    clear_model();
    #1 check("async_reset_out", bus.apb_read_data_out, 8'h00);
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;
    issue(1'b1, 9'h050, 8'h00); idle(1);
    issue(1'b1, 9'h012, 8'h00); idle(2);

    // Randomized mix, addresses biased to a small pool so reads hit writes
    pool = '{9'h000, 9'h001, 9'h0FF, 9'h100, 9'h101, 9'h1FF, 9'h050, 9'h150, 9'h012, 9'h112};
    repeat (80) begin
      rd = 1'($urandom);
      if ($urandom_range(0, 3) == 0) a = 9'($urandom);
      else                           a = pool[$urandom_range(0, 9)];
      issue(rd, a, 8'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(LAT + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_modport.md
APB_MODPORT -- requirements
Module: apb_modport

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9: external address width; MSB selects the slave, remaining bits address within the slave.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: data width of bus and slave memories.
REQ-003 pclk  input  1  single clock; all state updates on rising edge.
REQ-004 presetn  input  1  reset, asynchronous, active-low.
REQ-005 transfer  input  1  request; high = perform a transfer, low = no request.
REQ-006 READ_WRITE  input  1  direction; 1 = read, 0 = write.
REQ-007 apb_read_paddr  input  ADDR_WIDTH  read address.
REQ-008 apb_write_paddr  input  ADDR_WIDTH  write address.
REQ-009 apb_write_data  input  DATA_WIDTH  write data.
REQ-010 apb_read_data_out  output  DATA_WIDTH  data from the last completed read.

Function
REQ-011 SHALL contain one APB master and two APB slaves, each slave a 256 x DATA_WIDTH register memory.
REQ-012 Master FSM SHALL use states IDLE, SETUP and ACCESS.
REQ-013 IDLE: transfer=1 -> SETUP, latching READ_WRITE, the selected address (apb_read_paddr if read, else apb_write_paddr) and apb_write_data; transfer=0 -> stay IDLE.
REQ-014 SETUP: PSEL of the addressed slave high, PENABLE low; SHALL go unconditionally to ACCESS next cycle.
REQ-015 ACCESS: PENABLE high; while PREADY is low, stay in ACCESS.
REQ-016 ACCESS with PREADY high: if transfer=1, go to SETUP and latch the new request as in IDLE (back-to-back); otherwise go to IDLE.
REQ-017 Slave select: address bit 8 = 0 selects slave 1, = 1 selects slave 2; bits 7:0 index the memory; only one PSEL SHALL be high at a time.
REQ-018 Write SHALL commit to memory on the clock edge that completes ACCESS (PENABLE & PREADY).
REQ-019 Read: apb_read_data_out SHALL load PRDATA on the edge that completes ACCESS and hold it until the next read completes; writes SHALL NOT change it.
REQ-020 Latency without wait states: transfer sampled high at edge N -> write commits / read output updates at edge N+2.
REQ-021 Inputs SHALL be ignored in SETUP and ACCESS except transfer, which is sampled only at ACCESS completion.
REQ-022 Read of a never-written location SHALL return 0.

Reset
REQ-023 presetn low SHALL force FSM to IDLE, PSEL/PENABLE low, apb_read_data_out = 0 and all memory words = 0, immediately, without waiting for a clock edge.
REQ-024 Reset asserted mid-transfer SHALL abort the transfer with no memory write.
REQ-025 After presetn rises, the first transfer SHALL be sampled on the next rising edge.

Configuration
REQ-026 Macro APB_WAIT_STATE_EN: when defined, each slave SHALL hold PREADY low during the first ACCESS cycle, inserting one wait state, so latency becomes N+3; when undefined, PREADY SHALL be constantly high and latency is N+2.

Verification
REQ-027 Reset: presetn=0 for 2 cycles -> apb_read_data_out=0, FSM in IDLE.
REQ-028 Write 0xA5 to 0x012, then read 0x012 -> apb_read_data_out=0xA5 at edge N+2 of the read (N+3 with APB_WAIT_STATE_EN).
REQ-029 Write 0x11 to 0x034 and 0x22 to 0x134; read both -> 0x11 then 0x22 (slave isolation via bit 8).
REQ-030 transfer held high for 3 back-to-back writes to 0x000..0x002 -> SETUP re-entered directly from ACCESS, no IDLE cycle; readback of all three correct.
REQ-031 Read unwritten 0x1FF -> 0x00; then write 0x5A to 0x1FF -> apb_read_data_out stays 0x00 until the next read.
REQ-032 presetn asserted during SETUP of write 0xFF to 0x050 -> subsequent read of 0x050 returns 0x00.
